// File: rtl/sram_bus_arbiter.sv
// sram_bus_arbiter: shares one SRAM-like slave bus between inst and data masters (define ARB_RR_EN for round-robin)
module sram_bus_arbiter #(
   parameter int MAX_OUT = 2,
   parameter int PTR_W   = 1
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             inst_req,
   input  logic             inst_wr,
   input  logic [1:0]       inst_size,
   input  logic [3:0]       inst_wstrb,
   input  logic [31:0]      inst_addr,
   input  logic [31:0]      inst_wdata,
   output logic             inst_addr_ok,
   output logic             inst_data_ok,
   output logic [31:0]      inst_rdata,
   input  logic             data_req,
   input  logic             data_wr,
   input  logic [1:0]       data_size,
   input  logic [3:0]       data_wstrb,
   input  logic [31:0]      data_addr,
   input  logic [31:0]      data_wdata,
   output logic             data_addr_ok,
   output logic             data_data_ok,
   output logic [31:0]      data_rdata,
   output logic             s_req,
   output logic             s_wr,
   output logic [1:0]       s_size,
   output logic [3:0]       s_wstrb,
   output logic [31:0]      s_addr,
   output logic [31:0]      s_wdata,
   input  logic             s_addr_ok,
   input  logic             s_data_ok,
   input  logic [31:0]      s_rdata,
   output logic [PTR_W:0]   outstanding,
   output logic             resp_err
);
   localparam logic [PTR_W-1:0] LAST     = PTR_W'(MAX_OUT - 1);
   localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(MAX_OUT);
   logic [MAX_OUT-1:0] owner_q;
   logic [PTR_W-1:0]   rptr, wptr;
   logic [PTR_W:0]     count;
   logic lock, lock_owner, data_first, sel_valid, sel_owner, sel_req, full, push, pop, head;

`ifdef ARB_RR_EN
   logic rr_data;
   // priority flips to the other master after every address handshake
   always_ff @(posedge clk)
      if (!resetn) rr_data <= 1'b1;
      else if (push) rr_data <= !sel_owner;
   assign data_first = rr_data;
`else
   assign data_first = 1'b1;
`endif

   // grant selection, slave mux and per-master handshake routing (owner bit: 1=data)
   always_comb begin
      sel_valid    = lock || inst_req || data_req;
      sel_owner    = lock ? lock_owner : (data_first ? data_req : !inst_req);
      sel_req      = sel_owner ? data_req : inst_req;
      full         = count == FULL_CNT;
      s_req        = sel_valid && sel_req && !full;
      s_wr         = sel_valid && (sel_owner ? data_wr : inst_wr);
      s_size       = !sel_valid ? 2'b0  : sel_owner ? data_size  : inst_size;
      s_wstrb      = !sel_valid ? 4'b0  : sel_owner ? data_wstrb : inst_wstrb;
      s_addr       = !sel_valid ? 32'b0 : sel_owner ? data_addr  : inst_addr;
      s_wdata      = !sel_valid ? 32'b0 : sel_owner ? data_wdata : inst_wdata;
      push         = s_req && s_addr_ok;
      pop          = s_data_ok && count != '0;
      head         = owner_q[rptr];
      inst_addr_ok = push && !sel_owner;
      data_addr_ok = push && sel_owner;
      inst_data_ok = pop && !head;
      data_data_ok = pop && head;
      inst_rdata   = inst_data_ok ? s_rdata : 32'b0;
      data_rdata   = data_data_ok ? s_rdata : 32'b0;
      outstanding  = count;
   end

   // owner FIFO, address-phase lock and sticky stray-response flag
   always_ff @(posedge clk) begin
      if (!resetn) begin
         owner_q    <= '0;
         rptr       <= '0;
         wptr       <= '0;
         count      <= '0;
         lock       <= 1'b0;
         lock_owner <= 1'b0;
         resp_err   <= 1'b0;
      end else begin
         if (push) begin
            owner_q[wptr] <= sel_owner;
            wptr          <= wptr == LAST ? '0 : wptr + 1'b1;
         end
         if (pop) rptr <= rptr == LAST ? '0 : rptr + 1'b1;
         count <= count + {{PTR_W{1'b0}}, push} - {{PTR_W{1'b0}}, pop};
         if (push) lock <= 1'b0;
         else if (s_req) begin
            lock       <= 1'b1;
            lock_owner <= sel_owner;
         end
         if (s_data_ok && count == '0) resp_err <= 1'b1;
      end
   end
endmodule

// File: tb/tb_sram_bus_arbiter.sv
// tb_sram_bus_arbiter: directed checks of grant, lock, full, response routing and stray-response error
module tb_sram_bus_arbiter;
   logic clk = 1'b0, resetn;
   logic inst_req, inst_wr, data_req, data_wr;
   logic [1:0] inst_size, data_size, s_size;
   logic [3:0] inst_wstrb, data_wstrb, s_wstrb;
   logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata, inst_rdata, data_rdata;
   logic inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
   logic s_req, s_wr, s_addr_ok, s_data_ok;
   logic [31:0] s_addr, s_wdata, s_rdata;
   logic [1:0] outstanding;
   logic resp_err;
   int total = 0, pass_cnt = 0;

   always #5 clk = ~clk;

   sram_bus_arbiter dut (
      .clk(clk), .resetn(resetn),
      .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_wstrb(inst_wstrb),
      .inst_addr(inst_addr), .inst_wdata(inst_wdata), .inst_addr_ok(inst_addr_ok),
      .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
      .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_wstrb(data_wstrb),
      .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
      .data_data_ok(data_data_ok), .data_rdata(data_rdata),
      .s_req(s_req), .s_wr(s_wr), .s_size(s_size), .s_wstrb(s_wstrb), .s_addr(s_addr),
      .s_wdata(s_wdata), .s_addr_ok(s_addr_ok), .s_data_ok(s_data_ok), .s_rdata(s_rdata),
      .outstanding(outstanding), .resp_err(resp_err)
   );

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      inst_req = 0; inst_wr = 0; inst_size = 2; inst_wstrb = 4'hf; inst_addr = 0; inst_wdata = 0;
      data_req = 0; data_wr = 0; data_size = 2; data_wstrb = 4'hf; data_addr = 0; data_wdata = 0;
      s_addr_ok = 0; s_data_ok = 0; s_rdata = 0;
      resetn = 0;
      cyc();
      resetn = 1;
   endtask

   task automatic test_reset();
      do_reset();
      @(negedge clk);
      total++; if (outstanding !== 2'd0) $display("FAIL reset_outstanding: got %0d exp 0", outstanding); else pass_cnt++;
      total++; if (resp_err !== 1'b0) $display("FAIL reset_resp_err: got %b exp 0", resp_err); else pass_cnt++;
      total++; if (s_req !== 1'b0) $display("FAIL reset_s_req: got %b exp 0", s_req); else pass_cnt++;
      total++; if (s_addr !== 32'h0) $display("FAIL reset_s_addr: got %h exp 0", s_addr); else pass_cnt++;
      total++; if ({inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok} !== 4'b0) $display("FAIL reset_oks: got %b exp 0000", {inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}); else pass_cnt++;
   endtask

   task automatic test_single_fetch();
      do_reset();
      inst_req = 1; inst_addr = 32'h1c000000; s_addr_ok = 1;
      @(negedge clk);
      total++; if (s_req !== 1'b1 || s_addr !== 32'h1c000000) $display("FAIL fetch_s_addr: got req=%b addr=%h exp req=1 addr=1c000000", s_req, s_addr); else pass_cnt++;
      total++; if (inst_addr_ok !== 1'b1 || data_addr_ok !== 1'b0) $display("FAIL fetch_addr_ok: got inst=%b data=%b exp 1/0", inst_addr_ok, data_addr_ok); else pass_cnt++;
      cyc();
      inst_req = 0; s_addr_ok = 0;
      @(negedge clk);
      total++; if (outstanding !== 2'd1) $display("FAIL fetch_outstanding1: got %0d exp 1", outstanding); else pass_cnt++;
      cyc();
      s_data_ok = 1; s_rdata = 32'h02800c0c;
      @(negedge clk);
      total++; if (inst_data_ok !== 1'b1 || inst_rdata !== 32'h02800c0c) $display("FAIL fetch_resp: got ok=%b rdata=%h exp 1/02800c0c", inst_data_ok, inst_rdata); else pass_cnt++;
      total++; if (data_data_ok !== 1'b0 || data_rdata !== 32'h0) $display("FAIL fetch_data_idle: got ok=%b rdata=%h exp 0/0", data_data_ok, data_rdata); else pass_cnt++;
      cyc();
      s_data_ok = 0;
      @(negedge clk);
      total++; if (outstanding !== 2'd0) $display("FAIL fetch_outstanding0: got %0d exp 0", outstanding); else pass_cnt++;
   endtask

   task automatic test_contention();
      do_reset();
      inst_req = 1; inst_addr = 32'h1c000004; data_req = 1; data_addr = 32'h1000; s_addr_ok = 1;
      @(negedge clk);
      total++; if (s_addr !== 32'h1000 || data_addr_ok !== 1'b1 || inst_addr_ok !== 1'b0) $display("FAIL cont_first: got addr=%h dok=%b iok=%b exp 1000/1/0", s_addr, data_addr_ok, inst_addr_ok); else pass_cnt++;
      cyc();
      data_req = 0;
      @(negedge clk);
      total++; if (s_addr !== 32'h1c000004 || inst_addr_ok !== 1'b1) $display("FAIL cont_second: got addr=%h iok=%b exp 1c000004/1", s_addr, inst_addr_ok); else pass_cnt++;
      cyc();
      inst_req = 0; s_addr_ok = 0; s_data_ok = 1; s_rdata = 32'hAAAA;
      @(negedge clk);
      total++; if (outstanding !== 2'd2) $display("FAIL cont_outstanding: got %0d exp 2", outstanding); else pass_cnt++;
      total++; if (data_data_ok !== 1'b1 || data_rdata !== 32'hAAAA || inst_data_ok !== 1'b0 || inst_rdata !== 32'h0) $display("FAIL cont_resp1: got d=%b/%h i=%b/%h exp d=1/aaaa i=0/0", data_data_ok, data_rdata, inst_data_ok, inst_rdata); else pass_cnt++;
      cyc();
      s_rdata = 32'hBBBB;
      @(negedge clk);
      total++; if (inst_data_ok !== 1'b1 || inst_rdata !== 32'hBBBB || data_data_ok !== 1'b0 || data_rdata !== 32'h0) $display("FAIL cont_resp2: got i=%b/%h d=%b/%h exp i=1/bbbb d=0/0", inst_data_ok, inst_rdata, data_data_ok, data_rdata); else pass_cnt++;
      cyc();
      s_data_ok = 0;
      @(negedge clk);
      total++; if (outstanding !== 2'd0 || resp_err !== 1'b0) $display("FAIL cont_drain: got out=%0d err=%b exp 0/0", outstanding, resp_err); else pass_cnt++;
   endtask

   task automatic test_priority_after_data();
      logic [31:0] exp_addr;
`ifdef ARB_RR_EN
      exp_addr = 32'h1c000020;
`else
      exp_addr = 32'h3000;
`endif
      do_reset();
      inst_req = 1; inst_addr = 32'h1c000020; data_req = 1; data_addr = 32'h3000; s_addr_ok = 1;
      @(negedge clk);
      total++; if (data_addr_ok !== 1'b1) $display("FAIL prio_first: got data_addr_ok=%b exp 1", data_addr_ok); else pass_cnt++;
      cyc();
      @(negedge clk);
      total++; if (s_addr !== exp_addr) $display("FAIL prio_second: got addr=%h exp %h", s_addr, exp_addr); else pass_cnt++;
      cyc();
      inst_req = 0; data_req = 0; s_addr_ok = 0;
      @(negedge clk);
      total++; if (outstanding !== 2'd2) $display("FAIL prio_outstanding: got %0d exp 2", outstanding); else pass_cnt++;
   endtask

   task automatic test_lock();
      do_reset();
      inst_req = 1; inst_addr = 32'h1c000010;
      @(negedge clk);
      total++; if (s_req !== 1'b1 || s_addr !== 32'h1c000010 || inst_addr_ok !== 1'b0) $display("FAIL lock_c0: got req=%b addr=%h iok=%b exp 1/1c000010/0", s_req, s_addr, inst_addr_ok); else pass_cnt++;
      cyc();
      data_req = 1; data_addr = 32'h2000;
      for (int i = 1; i < 3; i++) begin
         @(negedge clk);
         total++; if (s_addr !== 32'h1c000010 || data_addr_ok !== 1'b0) $display("FAIL lock_hold%0d: got addr=%h dok=%b exp 1c000010/0", i, s_addr, data_addr_ok); else pass_cnt++;
         cyc();
      end
      s_addr_ok = 1;
      @(negedge clk);
      total++; if (s_addr !== 32'h1c000010 || inst_addr_ok !== 1'b1 || data_addr_ok !== 1'b0) $display("FAIL lock_release: got addr=%h iok=%b dok=%b exp 1c000010/1/0", s_addr, inst_addr_ok, data_addr_ok); else pass_cnt++;
      cyc();
      inst_req = 0;
      @(negedge clk);
      total++; if (s_addr !== 32'h2000 || data_addr_ok !== 1'b1) $display("FAIL lock_after: got addr=%h dok=%b exp 2000/1", s_addr, data_addr_ok); else pass_cnt++;
      cyc();
      data_req = 0; s_addr_ok = 0;
   endtask

   task automatic test_full();
      do_reset();
      inst_req = 1; inst_addr = 32'h1c000100; s_addr_ok = 1;
      cyc();
      inst_addr = 32'h1c000104;
      cyc();
      inst_req = 0; data_req = 1; data_addr = 32'h4000;
      @(negedge clk);
      total++; if (s_req !== 1'b0 || outstanding !== 2'd2) $display("FAIL full_block: got req=%b out=%0d exp 0/2", s_req, outstanding); else pass_cnt++;
      cyc();
      s_data_ok = 1; s_rdata = 32'h11111111;
      @(negedge clk);
      total++; if (s_req !== 1'b0 || data_addr_ok !== 1'b0) $display("FAIL full_pop_cycle: got req=%b dok=%b exp 0/0", s_req, data_addr_ok); else pass_cnt++;
      total++; if (inst_data_ok !== 1'b1 || inst_rdata !== 32'h11111111) $display("FAIL full_pop_resp: got %b/%h exp 1/11111111", inst_data_ok, inst_rdata); else pass_cnt++;
      cyc();
      s_data_ok = 0;
      @(negedge clk);
      total++; if (s_req !== 1'b1 || data_addr_ok !== 1'b1 || outstanding !== 2'd1) $display("FAIL full_resume: got req=%b dok=%b out=%0d exp 1/1/1", s_req, data_addr_ok, outstanding); else pass_cnt++;
      cyc();
      data_req = 0; s_addr_ok = 0;
      @(negedge clk);
      total++; if (outstanding !== 2'd2) $display("FAIL full_refill: got %0d exp 2", outstanding); else pass_cnt++;
      cyc();
      s_data_ok = 1; s_rdata = 32'h22222222;
      @(negedge clk);
      total++; if (inst_data_ok !== 1'b1 || data_data_ok !== 1'b0) $display("FAIL full_order1: got i=%b d=%b exp 1/0", inst_data_ok, data_data_ok); else pass_cnt++;
      cyc();
      s_rdata = 32'h33333333;
      @(negedge clk);
      total++; if (data_data_ok !== 1'b1 || data_rdata !== 32'h33333333) $display("FAIL full_order2: got %b/%h exp 1/33333333", data_data_ok, data_rdata); else pass_cnt++;
      cyc();
      s_data_ok = 0;
   endtask

   task automatic test_stray();
      do_reset();
      s_data_ok = 1; s_rdata = 32'hdeadbeef;
      @(negedge clk);
      total++; if (inst_data_ok !== 1'b0 || data_data_ok !== 1'b0 || inst_rdata !== 32'h0 || data_rdata !== 32'h0) $display("FAIL stray_ok: got i=%b d=%b exp 0/0", inst_data_ok, data_data_ok); else pass_cnt++;
      cyc();
      s_data_ok = 0;
      cyc();
      cyc();
      @(negedge clk);
      total++; if (resp_err !== 1'b1) $display("FAIL stray_err_held: got %b exp 1", resp_err); else pass_cnt++;
      resetn = 0;
      cyc();
      resetn = 1;
      @(negedge clk);
      total++; if (resp_err !== 1'b0) $display("FAIL stray_err_clear: got %b exp 0", resp_err); else pass_cnt++;
   endtask

   task automatic test_reset_mid();
      do_reset();
      inst_req = 1; inst_addr = 32'h1c000200; s_addr_ok = 1;
      cyc();
      inst_req = 0; s_addr_ok = 0; resetn = 0;
      cyc();
      resetn = 1; s_data_ok = 1; s_rdata = 32'h55;
      @(negedge clk);
      total++; if (outstanding !== 2'd0 || inst_data_ok !== 1'b0) $display("FAIL midrst_forget: got out=%0d iok=%b exp 0/0", outstanding, inst_data_ok); else pass_cnt++;
      cyc();
      s_data_ok = 0;
      @(negedge clk);
      total++; if (resp_err !== 1'b1) $display("FAIL midrst_err: got %b exp 1", resp_err); else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_single_fetch();
      test_contention();
      test_priority_after_data();
      test_lock();
      test_full();
      test_stray();
      test_reset_mid();
      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end
endmodule

// File: doc/sram_bus_arbiter.md
Name: sram_bus_arbiter

Overview:
- Shares one SRAM-like slave bus (req/addr_ok/data_ok) between the instruction-fetch master (IF stage) and the data master (EXE issues, MEM consumes).
- Grants one request per cycle, keeps a grant locked until the address handshake completes, and tracks outstanding transactions in an in-order owner FIFO.
- Routes each data_ok/rdata back to the master that issued the transaction.
- Sits between the pipeline stages and the SRAM/bridge at top level.

Parameters:
- MAX_OUT, 2, max outstanding transactions (owner FIFO depth), power of two, 1..8.
- PTR_W, 1, log2(MAX_OUT), minimum 1.

Ports:
- clk  in  1  clock, rising edge.
- resetn  in  1  synchronous, active-low reset.
- inst_req  in  1  instruction master request.
- inst_wr  in  1  write flag; always 0 in normal use but passed through.
- inst_size  in  2  0=byte, 1=half, 2=word.
- inst_wstrb  in  4  byte strobes.
- inst_addr  in  32  address.
- inst_wdata  in  32  write data.
- inst_addr_ok  out  1  address accepted.
- inst_data_ok  out  1  response for inst.
- inst_rdata  out  32  read data.
- data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata  in  1/1/2/4/32/32  data master, same meanings.
- data_addr_ok, data_data_ok  out  1  data master handshakes.
- data_rdata  out  32  read data.
- s_req  out  1  slave request.
- s_wr  out  1  write flag.
- s_size  out  2  size.
- s_wstrb  out  4  strobes.
- s_addr  out  32  address.
- s_wdata  out  32  write data.
- s_addr_ok  in  1  slave address accepted.
- s_data_ok  in  1  slave response valid.
- s_rdata  in  32  slave read data.
- outstanding  out  PTR_W+1  current FIFO occupancy.
- resp_err  out  1  sticky error flag.

Behaviour:
- Reset (resetn=0 at posedge):
  - FIFO empty, occupancy 0, lock cleared, resp_err=0.
  - All addr_ok/data_ok low, s_req low.
  - In-flight responses are forgotten.
- Grant selection (combinational):
  - If the lock is set, sel = locked owner.
  - Otherwise data_req has priority over inst_req.
  - No request means no grant.
- Slave request:
  - s_req = (selected master's req) && !full.
  - s_wr/size/wstrb/addr/wdata muxed from the selected master; all zero when idle.
- Lock:
  - Set when s_req=1 && s_addr_ok=0; it records the owner.
  - Cleared on the cycle s_req && s_addr_ok.
  - While locked, the other master cannot be granted even if it has higher priority.
- Address handshake:
  - s_req && s_addr_ok pushes the owner bit (0=inst, 1=data) into the FIFO.
  - The same-cycle addr_ok is forwarded only to the owner; the other master's addr_ok stays 0.
- Full:
  - occupancy==MAX_OUT forces s_req=0.
  - A pop in the same cycle does not re-enable s_req; the push resumes next cycle.
- Response:
  - s_data_ok with a non-empty FIFO pops the head.
  - Asserts the owner's data_ok for that cycle only.
  - Routes s_rdata to the owner's rdata; the other master's rdata holds 0.
  - Responses are strictly in order; zero-cycle combinational pass-through.
- Simultaneous push and pop (not full): occupancy unchanged, pointers both advance.
- Wrap-around: read/write pointers wrap modulo MAX_OUT.
- s_data_ok with the FIFO empty: ignored (no data_ok to either master), and resp_err sets and holds until reset.
- Reset mid-transaction: the lock and FIFO clear; late slave responses after reset set resp_err.

Optional Feature:
- ARB_RR_EN
  - Defined: unlocked arbitration is round-robin. After a data grant handshake, inst has priority next; after an inst handshake, data has priority next. The priority pointer resets to data-first.
  - Undefined: fixed data-over-inst priority as described above.
  - Lock, FIFO and routing behaviour are identical in both builds.

Test Plan:
- Single fetch:
  - inst_req, addr 0x1c000000; s_addr_ok same cycle; s_data_ok 2 cycles later with rdata 0x02800c0c.
  - Expect: inst_addr_ok=1 cycle0, inst_data_ok=1 with inst_rdata=0x02800c0c, data_* all 0, outstanding 1→0.
- Contention:
  - inst_req and data_req (load 0x1000) both high, s_addr_ok=1.
  - Expect: data granted first (s_addr=0x1000), inst next cycle.
  - Responses 0xAAAA then 0xBBBB go to data then inst respectively.
  - With ARB_RR_EN after a prior data grant: inst first.
- Lock:
  - inst_req alone, s_addr_ok low 3 cycles; data_req rises at cycle 1.
  - Expect: s_addr stays the inst address until addr_ok; data is granted only afterwards.
- Full (MAX_OUT=2):
  - Two accepted reads with no responses; a third request → s_req=0.
  - A data_ok in the cycle the third request is pending: s_req still 0 that cycle, 1 the next; outstanding 2→1→2.
- Stray response:
  - s_data_ok with an empty FIFO.
  - Expect: no master data_ok; resp_err=1 and held; resetn low one cycle → resp_err=0.
